// File: rtl/smt_multiport_regfile.sv
// Multi-threaded register file: NUM_RD combinational read ports, NUM_WR write ports, per-thread clear engine.
// Reads are zero-latency with same-cycle write bypass; writes and sweep steps commit on the next rising edge.
// Clear requests are accepted only when o_Clr_Ready=1; the requester holds i_Clr_Valid until it is taken.
module smt_multiport_regfile #(
   parameter int DATA_WIDTH      = 32,
   parameter int NUM_THREADS     = 4,
   parameter int REGS_PER_THREAD = 32,
   parameter int NUM_RD          = 8,
   parameter int NUM_WR          = 4,
   localparam int TID_W  = $clog2(NUM_THREADS),
   localparam int RID_W  = $clog2(REGS_PER_THREAD),
   localparam int ADDR_W = TID_W + RID_W
) (
   input  logic                         i_Clk,
   input  logic                         i_Rst,
   input  logic [NUM_RD*ADDR_W-1:0]     i_Read_Addr,
   output logic [NUM_RD*DATA_WIDTH-1:0] o_Read_Data,
   input  logic [NUM_WR-1:0]            i_Write_Enable,
   input  logic [NUM_WR*ADDR_W-1:0]     i_Write_Addr,
   input  logic [NUM_WR*DATA_WIDTH-1:0] i_Write_Data,
   input  logic                         i_Clr_Valid,
   input  logic [TID_W-1:0]             i_Clr_Tid,
   output logic                         o_Clr_Ready,
   output logic                         o_Clr_Busy,
   output logic [TID_W-1:0]             o_Clr_Tid,
   output logic                         o_Clr_Done
);

   localparam int NUM_REGS = NUM_THREADS * REGS_PER_THREAD;
   // Counter is one bit wider than a register id so the terminal compare cannot wrap.
   localparam logic [RID_W:0] LAST_RID = (RID_W+1)'(REGS_PER_THREAD - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SWEEP,
      ST_DONE
   } clr_state_t;

   clr_state_t       state_q, state_d;
   logic [TID_W-1:0] clr_tid_q, clr_tid_d;
   logic [RID_W:0]   cnt_q, cnt_d;
   logic             clr_accept;

   logic [DATA_WIDTH-1:0] mem [NUM_REGS];

   logic [ADDR_W-1:0]     wr_addr [NUM_WR];
   logic [DATA_WIDTH-1:0] wr_data [NUM_WR];
   logic [NUM_WR-1:0]     wr_eff;
   logic [ADDR_W-1:0]     rd_addr [NUM_RD];

   genvar g;
   generate
      for (g = 0; g < NUM_WR; g++) begin : g_wr_unpack
         assign wr_addr[g] = i_Write_Addr[g*ADDR_W +: ADDR_W];
         assign wr_data[g] = i_Write_Data[g*DATA_WIDTH +: DATA_WIDTH];
      end
      for (g = 0; g < NUM_RD; g++) begin : g_rd_unpack
         assign rd_addr[g] = i_Read_Addr[g*ADDR_W +: ADDR_W];
      end
   endgenerate

   assign o_Clr_Tid = clr_tid_q;

   // Clear FSM state, target thread and sweep counter registers.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q   <= ST_IDLE;
         clr_tid_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         clr_tid_q <= clr_tid_d;
         cnt_q     <= cnt_d;
      end
   end

   // Clear FSM next state and handshake outputs.
   always_comb begin
      state_d     = state_q;
      clr_tid_d   = clr_tid_q;
      cnt_d       = cnt_q;
      o_Clr_Ready = 1'b0;
      o_Clr_Busy  = 1'b0;
      o_Clr_Done  = 1'b0;
      clr_accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            o_Clr_Ready = 1'b1;
            if (i_Clr_Valid) begin
               clr_accept = 1'b1;
               clr_tid_d  = i_Clr_Tid;
               cnt_d      = (RID_W+1)'(1);
               state_d    = ST_SWEEP;
            end
         end
         ST_SWEEP: begin
            o_Clr_Busy = 1'b1;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == LAST_RID) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            o_Clr_Done = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // External write qualification: drop rid 0 and anything aimed at the thread being cleared.
   always_comb begin
      wr_eff = '0;
      for (int w = 0; w < NUM_WR; w++) begin
         wr_eff[w] = i_Write_Enable[w]
                   && (wr_addr[w][RID_W-1:0] != '0)
                   && !(o_Clr_Busy && (wr_addr[w][ADDR_W-1:RID_W] == clr_tid_q))
                   && !(clr_accept && (wr_addr[w][ADDR_W-1:RID_W] == i_Clr_Tid));
      end
   end

   // Read ports: stored value, overridden by the highest matching live write, forced to zero for rid 0 or a blocked thread.
   always_comb begin
      o_Read_Data = '0;
      for (int r = 0; r < NUM_RD; r++) begin
         o_Read_Data[r*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr[r]];
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_eff[w] && (wr_addr[w] == rd_addr[r])) begin
               o_Read_Data[r*DATA_WIDTH +: DATA_WIDTH] = wr_data[w];
            end
         end
         if ((rd_addr[r][RID_W-1:0] == '0)
             || (o_Clr_Busy && (rd_addr[r][ADDR_W-1:RID_W] == clr_tid_q))
             || (clr_accept && (rd_addr[r][ADDR_W-1:RID_W] == i_Clr_Tid))) begin
            o_Read_Data[r*DATA_WIDTH +: DATA_WIDTH] = '0;
         end
      end
   end

   // Storage update: later write ports override earlier ones; the sweep has its own path into a blocked thread.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_eff[w]) begin
               mem[wr_addr[w]] <= wr_data[w];
            end
         end
         if (o_Clr_Busy) begin
            mem[{clr_tid_q, cnt_q[RID_W-1:0]}] <= '0;
         end
      end
   end

endmodule

// File: tb/tb_smt_multiport_regfile.sv
// Bench for smt_multiport_regfile: directed stimulus pushes expected values, a monitor compares them.
// Checks are taken on the falling edge of the cycle in which the stimulus was applied.
// Clear handshake is driven directly; the bench holds i_Clr_Valid until it is accepted.
module tb_smt_multiport_regfile;

   localparam int DW = 32;
   localparam int AW = 7;
   localparam int NR = 8;
   localparam int NW = 4;

   logic             clk;
   logic             rst;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NW-1:0]    we;
   logic [NW*AW-1:0] wr_addr;
   logic [NW*DW-1:0] wr_dat;
   logic             clr_vld;
   logic [1:0]       clr_tid_in;
   logic             clr_rdy;
   logic             clr_busy;
   logic [1:0]       clr_tid_out;
   logic             clr_done;

   smt_multiport_regfile dut (
      .i_Clk          (clk),
      .i_Rst          (rst),
      .i_Read_Addr    (rd_addr),
      .o_Read_Data    (rd_data),
      .i_Write_Enable (we),
      .i_Write_Addr   (wr_addr),
      .i_Write_Data   (wr_dat),
      .i_Clr_Valid    (clr_vld),
      .i_Clr_Tid      (clr_tid_in),
      .o_Clr_Ready    (clr_rdy),
      .o_Clr_Busy     (clr_busy),
      .o_Clr_Tid      (clr_tid_out),
      .o_Clr_Done     (clr_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // kind: 0 read port idx, 1 ready, 2 busy, 3 done, 4 clear tid
   typedef struct {
      int          kind;
      int          idx;
      logic [31:0] exp;
   } exp_t;

   exp_t sbq[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Monitor: on each falling edge, compare every expectation queued for this cycle.
   initial begin
      exp_t        e;
      logic [31:0] act;
      string       nm;
      forever begin
         @(negedge clk);
         while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.kind)
               0: begin act = rd_data[e.idx*DW +: DW]; nm = $sformatf("rd_port%0d", e.idx); end
               1: begin act = {31'b0, clr_rdy};  nm = "clr_ready"; end
               2: begin act = {31'b0, clr_busy}; nm = "clr_busy"; end
               3: begin act = {31'b0, clr_done}; nm = "clr_done"; end
               default: begin act = {30'b0, clr_tid_out}; nm = "clr_tid"; end
            endcase
            n_chk++;
            if (act !== e.exp) begin
               n_fail++;
               $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, e.exp);
            end
         end
      end
   end

   function automatic logic [6:0] ad(input int t, input int r);
      return {t[1:0], r[4:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int k, input int t, input int r);
      rd_addr[k*AW +: AW] = ad(t, r);
   endtask

   task automatic set_wr(input int k, input int t, input int r, input logic [31:0] d);
      we[k]                = 1'b1;
      wr_addr[k*AW +: AW]  = ad(t, r);
      wr_dat[k*DW +: DW]   = d;
   endtask

   task automatic exp_rd(input int k, input logic [31:0] v);
      exp_t e;
      e.kind = 0; e.idx = k; e.exp = v;
      sbq.push_back(e);
   endtask

   task automatic exp_ctl(input logic rdy, input logic busy, input logic done, input int tid);
      exp_t e;
      e.idx = 0;
      e.kind = 1; e.exp = {31'b0, rdy};  sbq.push_back(e);
      e.kind = 2; e.exp = {31'b0, busy}; sbq.push_back(e);
      e.kind = 3; e.exp = {31'b0, done}; sbq.push_back(e);
      e.kind = 4; e.exp = tid;           sbq.push_back(e);
   endtask

   initial begin
      int wait_cyc;
      rst        = 1'b1;
      rd_addr    = '0;
      we         = '0;
      wr_addr    = '0;
      wr_dat     = '0;
      clr_vld    = 1'b0;
      clr_tid_in = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_chk++;
      if ((clr_rdy !== 1'b1) || (clr_busy !== 1'b0) || (clr_done !== 1'b0) || (clr_tid_out !== 2'd0)) begin
         n_fail++;
         $display("FAIL reset_state at %0t: rdy=%b busy=%b done=%b tid=%0d", $time, clr_rdy, clr_busy, clr_done, clr_tid_out);
      end

      // Reset state: assorted reads are zero, engine idle.
      for (int k = 0; k < NR; k++) begin
         set_rd(k, k % 4, k * 3 + 1);
         exp_rd(k, 32'h0);
      end
      exp_ctl(1'b1, 1'b0, 1'b0, 0);
      tick();

      // Write {t2,r5} with same-cycle bypass, then stored value.
      set_wr(0, 2, 5, 32'hDEADBEEF);
      set_rd(3, 2, 5);
      exp_rd(3, 32'hDEADBEEF);
      tick();
      we = '0;
      exp_rd(3, 32'hDEADBEEF);
      // Write to rid 0 is dropped and reads as zero.
      set_wr(0, 1, 0, 32'h1);
      set_rd(1, 1, 0);
      exp_rd(1, 32'h0);
      tick();
      we = '0;
      exp_rd(1, 32'h0);
      tick();

      // Ports 1 and 3 collide on {t0,r7}: port 3 wins for bypass and storage.
      set_wr(1, 0, 7, 32'h11);
      set_wr(3, 0, 7, 32'h33);
      set_rd(0, 0, 7);
      exp_rd(0, 32'h33);
      tick();
      we = '0;
      exp_rd(0, 32'h33);
      tick();

      // Fill t3 r1..r31 four registers per cycle.
      for (int c = 0; c < 8; c++) begin
         we = '0;
         for (int w = 0; w < NW; w++) begin
            if (c * 4 + w + 1 <= 31) set_wr(w, 3, c * 4 + w + 1, 32'h3000 + c * 4 + w + 1);
         end
         tick();
      end
      we = '0;
      for (int k = 0; k < NR; k++) begin
         set_rd(k, 3, k + 1);
         exp_rd(k, 32'h3000 + k + 1);
      end
      tick();

      // Accept cycle: t3 is already blocked for reads.
      clr_vld    = 1'b1;
      clr_tid_in = 2'd3;
      set_rd(0, 3, 1);
      exp_rd(0, 32'h0);
      exp_ctl(1'b1, 1'b0, 1'b0, 0);
      tick();
      clr_vld = 1'b0;

      // Sweep of t3: 31 busy cycles, other threads keep working.
      for (int i = 1; i <= 31; i++) begin
         we = '0;
         set_wr(1, 0, 9, 32'hA000 + i);
         if (i == 5) set_wr(0, 3, 4, 32'h0BAD);
         if (i == 10) begin
            clr_vld    = 1'b1;
            clr_tid_in = 2'd1;
         end
         set_rd(0, 3, i);
         set_rd(1, 3, 4);
         set_rd(2, 3, 31);
         set_rd(3, 0, 7);
         set_rd(4, 0, 9);
         set_rd(5, 2, 5);
         exp_rd(0, 32'h0);
         exp_rd(1, 32'h0);
         exp_rd(2, 32'h0);
         exp_rd(3, 32'h33);
         exp_rd(4, 32'hA000 + i);
         exp_rd(5, 32'hDEADBEEF);
         exp_ctl(1'b0, 1'b1, 1'b0, 3);
         tick();
      end

      // DONE cycle: storage of t3 is now really zero, pending request still waiting.
      we = '0;
      set_rd(0, 3, 4);
      set_rd(1, 3, 1);
      set_rd(2, 3, 31);
      set_rd(6, 3, 16);
      exp_rd(0, 32'h0);
      exp_rd(1, 32'h0);
      exp_rd(2, 32'h0);
      exp_rd(6, 32'h0);
      exp_rd(4, 32'hA000 + 31);
      exp_ctl(1'b0, 1'b0, 1'b1, 3);
      tick();

      // Held request for t1 is accepted now.
      exp_ctl(1'b1, 1'b0, 1'b0, 3);
      tick();
      clr_vld = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         exp_ctl(1'b0, 1'b1, 1'b0, 1);
         if (i == 10) rst = 1'b1;
         tick();
      end

      // Reset mid-sweep: aborted, storage cleared, immediate new request.
      rst        = 1'b0;
      clr_vld    = 1'b1;
      clr_tid_in = 2'd2;
      set_rd(3, 0, 7);
      set_rd(4, 0, 9);
      set_rd(5, 2, 5);
      exp_rd(3, 32'h0);
      exp_rd(4, 32'h0);
      exp_rd(5, 32'h0);
      exp_ctl(1'b1, 1'b0, 1'b0, 0);
      tick();
      clr_vld = 1'b0;
      for (int i = 1; i <= 31; i++) begin
         exp_ctl(1'b0, 1'b1, 1'b0, 2);
         tick();
      end
      exp_ctl(1'b0, 1'b0, 1'b1, 2);
      tick();
      exp_ctl(1'b1, 1'b0, 1'b0, 2);
      tick();

      // Bounded wait for the engine to be idle again.
      wait_cyc = 0;
      while ((clr_rdy !== 1'b1) && (wait_cyc < 33)) begin
         tick();
         wait_cyc++;
      end
      n_chk++;
      if (clr_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_ready wait expired at %0t after %0d cycles", $time, wait_cyc);
      end

      @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
